// File: rtl/spi_xfer_sched.sv
// Two-requester SPI master scheduler: round-robin grant, per-requester chip select,
// mode-0 MSB-first full-duplex shifting of one W_DATA-bit word per transaction.
module spi_xfer_sched #(
   parameter int W_DATA   = 32,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_i,
   input  logic [W_DATA-1:0] wdata0_i,
   input  logic [W_DATA-1:0] wdata1_i,
   output logic [1:0]        gnt_o,
   output logic [1:0]        done_o,
   output logic [W_DATA-1:0] rdata_o,
   output logic              busy_o,
   output logic              spi_sclk_o,
   output logic              spi_mosi_o,
   input  logic              spi_miso_i,
   output logic [1:0]        spi_cs_n_o
);

   localparam int CNT_MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int CNT_MAX    = (CNT_MAX_SH > CLK_DIV) ? CNT_MAX_SH : CLK_DIV;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);
   localparam int HALF_W     = $clog2(2 * W_DATA + 1);

   localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_END   = HALF_W'(2 * W_DATA);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [HALF_W-1:0]   half_q;
   logic [W_DATA-1:0]   tx_q;
   logic [W_DATA-1:0]   rx_q;
   logic                idx_q;
   logic                last_q;
   logic [1:0]          gnt_q;
   logic [1:0]          done_q;
   logic [W_DATA-1:0]   rdata_q;
   logic                busy_q;
   logic                sclk_q;
   logic                mosi_q;
   logic [1:0]          cs_n_q;

   logic                pick_d;
   logic [W_DATA-1:0]   sel_wdata_d;
   logic [HALF_W-1:0]   half_d;
   logic [W_DATA-1:0]   rx_d;

   // Arbitration choice and shift helpers; a tie goes to the requester not served last.
   always_comb begin
      pick_d = 1'b0;
      case (req_i)
         2'b10:   pick_d = 1'b1;
         2'b11:   pick_d = ~last_q;
         default: pick_d = 1'b0;
      endcase
      sel_wdata_d = pick_d ? wdata1_i : wdata0_i;
      half_d      = half_q + HALF_W'(1);
      rx_d        = {rx_q[W_DATA-2:0], spi_miso_i};
   end

   // Transaction sequencer. half_q counts SCLK half periods: even halves are high
   // (rising edge at their start), odd halves low; the word ends after 2*W_DATA halves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         half_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         idx_q   <= 1'b0;
         last_q  <= 1'b1;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 2'b11;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_i != 2'b00) begin
                  state_q <= ST_SETUP;
                  cnt_q   <= '0;
                  idx_q   <= pick_d;
                  gnt_q   <= {pick_d, ~pick_d};
                  cs_n_q  <= {~pick_d, pick_d};
                  busy_q  <= 1'b1;
                  mosi_q  <= sel_wdata_d[W_DATA-1];
                  tx_q    <= {sel_wdata_d[W_DATA-2:0], 1'b0};
                  rx_q    <= '0;
               end
            end
            ST_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  state_q <= ST_SHIFT;
                  cnt_q   <= '0;
                  half_q  <= '0;
                  sclk_q  <= 1'b1;
                  rx_q    <= rx_d;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q  <= '0;
                  half_q <= half_d;
                  if (half_d == HALF_END) begin
                     state_q <= ST_HOLD;
                  end else if (half_d[0]) begin
                     sclk_q <= 1'b0;
                     mosi_q <= tx_q[W_DATA-1];
                     tx_q   <= {tx_q[W_DATA-2:0], 1'b0};
                  end else begin
                     sclk_q <= 1'b1;
                     rx_q   <= rx_d;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_q <= ST_DONE;
                  cnt_q   <= '0;
                  cs_n_q  <= 2'b11;
                  done_q  <= gnt_q;
                  rdata_q <= rx_q;
                  last_q  <= idx_q;
                  mosi_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               gnt_q   <= 2'b00;
               done_q  <= 2'b00;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               gnt_q   <= 2'b00;
               done_q  <= 2'b00;
               busy_q  <= 1'b0;
               sclk_q  <= 1'b0;
               mosi_q  <= 1'b0;
               cs_n_q  <= 2'b11;
            end
         endcase
      end
   end

   assign gnt_o      = gnt_q;
   assign done_o     = done_q;
   assign rdata_o    = rdata_q;
   assign busy_o     = busy_q;
   assign spi_sclk_o = sclk_q;
   assign spi_mosi_o = mosi_q;
   assign spi_cs_n_o = cs_n_q;

endmodule
